// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, FSM state encoding and majority helper shared by UART blocks
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_e;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: baud counter with 2-of-3 majority bit decision at mid-bit
module uart_bit_sampler import uart_pkg::*; #(
  parameter int BAUD_DIV = 434
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic en,
  input  logic clr,
  input  logic line,
  output logic bit_valid,
  output logic bit_val,
  output logic wrap
);
  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] MID = 16'(BAUD_DIV / 2);
  logic [15:0] cnt;
  logic [1:0] smp;
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      cnt <= '0;
      smp <= '0;
    end else begin
      cnt <= (!en || clr || wrap) ? '0 : cnt + 16'd1;
      if (cnt == MID - 16'd1) smp[0] <= line;
      if (cnt == MID) smp[1] <= line;
    end
  assign wrap = en && cnt == LAST;
  assign bit_valid = en && cnt == MID + 16'd1;
  assign bit_val = maj3(smp[0], smp[1], line);
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with parity, framing and break detection
module uart_rx_cfg import uart_pkg::*; #(
  parameter int BAUD_DIV = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       po_flag,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_flag
);
  state_e state, state_n;
  logic [2:0] sync;
  logic warm, armed, fall;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0] bit_cnt;
  logic stop_cnt, par_acc, any_one, ferr_acc;
  logic bit_valid, bit_val, wrap;
  logic last_stop, done, ferr_now, brk_now, perr_now;
  // armed only once the line has really been seen high after reset
  assign fall = armed && sync[2] && !sync[1];
  uart_bit_sampler #(.BAUD_DIV(BAUD_DIV)) u_sampler (
    .sclk(sclk),
    .s_rst_n(s_rst_n),
    .en(state != IDLE),
    .clr(state_n != state),
    .line(sync[1]),
    .bit_valid(bit_valid),
    .bit_val(bit_val),
    .wrap(wrap)
  );
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (fall) state_n = START;
      START: if (bit_valid && bit_val) state_n = IDLE; else if (wrap) state_n = DATA;
      DATA: if (wrap && bit_cnt == 3'(DATA_BITS - 1)) state_n = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
      uart_pkg::PARITY: if (wrap) state_n = STOP;
      STOP: if (done) state_n = brk_now ? BRK_WAIT : IDLE;
      BRK_WAIT: if (sync[1]) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    last_stop = STOP_BITS == 1 || stop_cnt;
    done = state == STOP && bit_valid && last_stop;
    ferr_now = ferr_acc | ~bit_val;
    brk_now = ferr_now && !any_one;
    perr_now = PARITY == PAR_ODD ? ~par_acc : PARITY == PAR_EVEN ? par_acc : 1'b0;
  end
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      sync <= '1;
      warm <= 1'b0;
      armed <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      par_acc <= 1'b0;
      any_one <= 1'b0;
      ferr_acc <= 1'b0;
      rx_data <= '0;
      po_flag <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      break_flag <= 1'b0;
    end else begin
      sync <= {sync[1:0], rs232_rx};
      warm <= 1'b1;
      armed <= armed | (warm & sync[0]);
      po_flag <= done;
      parity_err <= done & perr_now;
      frame_err <= done & ferr_now;
      break_flag <= done & brk_now;
      if (done) rx_data <= 8'(shreg);
      if (state == IDLE) begin
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
        par_acc <= 1'b0;
        any_one <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (bit_valid && (state == DATA || state == uart_pkg::PARITY)) begin
        par_acc <= par_acc ^ bit_val;
        any_one <= any_one | bit_val;
      end
      if (bit_valid && state == DATA) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if (wrap && state == DATA) bit_cnt <= bit_cnt + 3'd1;
      if (bit_valid && state == STOP) ferr_acc <= ferr_acc | ~bit_val;
      if (wrap && state == STOP) stop_cnt <= 1'b1;
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg across 8N1, 7E1 and 8N2 formats
module tb_uart_rx_cfg;
  localparam int B = 16;
  localparam int M = B / 2;
  localparam int N = 3;
  localparam int DB [N] = '{8, 7, 8};
  localparam int PR [N] = '{0, 2, 0};
  localparam int SB [N] = '{1, 1, 2};
  typedef struct {logic [7:0] d; logic pe; logic fe; logic bk; int cyc;} exp_t;
  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;
  logic line [N];
  logic [7:0] rxd [N];
  logic po [N];
  logic pe [N];
  logic fe [N];
  logic bk [N];
  exp_t exp_q [N][$];
  exp_t mon_e;
  logic [7:0] last_d [N];
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;
  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_rx_cfg #(.BAUD_DIV(B), .DATA_BITS(DB[g]), .PARITY(PR[g]), .STOP_BITS(SB[g])) u_dut (
      .sclk(sclk),
      .s_rst_n(s_rst_n),
      .rs232_rx(line[g]),
      .rx_data(rxd[g]),
      .po_flag(po[g]),
      .parity_err(pe[g]),
      .frame_err(fe[g]),
      .break_flag(bk[g])
    );
  end
  function automatic void check(input string name, input int i, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s[%0d] got %0h want %0h at cycle %0d", name, i, act, req, cyc);
  endfunction
  function automatic void check_zero();
    for (int i = 0; i < N; i++)
      check("reset_outs", i, int'({rxd[i], po[i], pe[i], fe[i], bk[i]}), 0);
  endfunction
  // latency reference: line fall -> two sync flops + edge register, then one bit period per frame bit
  function automatic int due(input int nbits);
    return cyc + (nbits - 1) * B + M + 5;
  endfunction
  always @(negedge sclk) begin
    for (int i = 0; i < N; i++) begin
      if (!s_rst_n) last_d[i] = 8'h00;
      else if (po[i]) begin
        if (exp_q[i].size() == 0) check("unexpected_po", i, exp_q[i].size(), 1);
        else begin
          mon_e = exp_q[i].pop_front();
          check("rx_data", i, int'(rxd[i]), int'(mon_e.d));
          check("pe_fe_bk", i, int'({pe[i], fe[i], bk[i]}), int'({mon_e.pe, mon_e.fe, mon_e.bk}));
          check("po_timing", i, int'(cyc >= mon_e.cyc - 2 && cyc <= mon_e.cyc + 2), 1);
          last_d[i] = mon_e.d;
        end
      end else check("idle_hold", i, int'({rxd[i], pe[i], fe[i], bk[i]}), int'({last_d[i], 3'b000}));
    end
  end
  task automatic send_frame(input int i, input logic [7:0] d, input bit bad_par,
                            input logic [1:0] stops, input int rst_bit, input int gap);
    logic bits [$];
    logic [7:0] dm;
    logic pbit;
    int ones;
    exp_t e;
    dm = d & 8'((1 << DB[i]) - 1);
    ones = $countones(dm);
    pbit = ((PR[i] == 2) ? ones[0] : ~ones[0]) ^ bad_par;
    bits.push_back(1'b0);
    for (int k = 0; k < DB[i]; k++) bits.push_back(dm[k]);
    if (PR[i] != 0) bits.push_back(pbit);
    for (int k = 0; k < SB[i]; k++) bits.push_back(stops[k]);
    e.d = dm;
    e.pe = PR[i] != 0 && ((ones + int'(pbit)) % 2) != (PR[i] == 1 ? 1 : 0);
    e.fe = !stops[0] || (SB[i] == 2 && !stops[1]);
    e.bk = e.fe && dm == 8'h00 && (PR[i] == 0 || !pbit);
    e.cyc = due(bits.size());
    if (rst_bit < 0) exp_q[i].push_back(e);
    foreach (bits[n]) begin
      line[i] = bits[n];
      for (int c = 0; c < B; c++) begin
        s_rst_n = !(n == rst_bit && c < 5);
        if (!s_rst_n) begin
          #1;
          check_zero();
        end
        @(negedge sclk);
      end
    end
    line[i] = 1'b1;
    repeat (gap) @(negedge sclk);
  endtask
  initial begin
    exp_t e;
    logic [1:0] st;
    for (int i = 0; i < N; i++) begin
      line[i] = 1'b1;
      last_d[i] = 8'h00;
    end
    repeat (3) @(negedge sclk);
    check_zero();
    s_rst_n = 1'b1;
    repeat (6) @(negedge sclk);
    send_frame(0, 8'hA5, 1'b0, 2'b11, -1, 4);
    line[0] = 1'b0;
    repeat (5) @(negedge sclk);
    line[0] = 1'b1;
    repeat (40) @(negedge sclk);
    send_frame(0, 8'h3C, 1'b0, 2'b11, -1, 4);
    e.d = 8'h00;
    e.pe = 1'b0;
    e.fe = 1'b1;
    e.bk = 1'b1;
    e.cyc = due(10);
    exp_q[0].push_back(e);
    line[0] = 1'b0;
    repeat (30 * B) @(negedge sclk);
    line[0] = 1'b1;
    repeat (30) @(negedge sclk);
    send_frame(0, 8'h55, 1'b0, 2'b11, -1, 4);
    send_frame(0, 8'hF0, 1'b0, 2'b11, 3, 20);
    send_frame(0, 8'h0F, 1'b0, 2'b11, -1, 4);
    send_frame(1, 8'h35, 1'b1, 2'b11, -1, 4);
    send_frame(2, 8'h81, 1'b0, 2'b01, -1, 8);
    for (int i = 0; i < N; i++)
      for (int f = 0; f < 25; f++) begin
        st = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        send_frame(i, 8'($urandom), $urandom_range(0, 3) == 0, st, -1,
                   (st == 2'b11) ? $urandom_range(0, 3) : $urandom_range(6, 12));
      end
    repeat (50) @(negedge sclk);
    for (int i = 0; i < N; i++) check("drain", i, exp_q[i].size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
